alu_sequencer: RTL and testbench

- Moore-style controller that sequences the shared iterative arithmetic datapath (shift-add multiply, restoring divide, digit-by-digit sqrt) after the input stage has latched both operands and raised its start pulse.
- Captures the opcode and operand flags, screens illegal operations, then drives the datapath through init/step cycles with an iteration counter.
- Reports busy, done, error and result sign to the output/display stage.

---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/iter_counter.sv | 36 +++
 rtl/alu_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and helpers for the ALU sequencer: opcode and
//                state encodings plus the per-opcode iteration count.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_SQRT = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSV  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_INIT   = 3'd2,
    ST_ITER   = 3'd3,
    ST_FINISH = 3'd4,
    ST_ERROR  = 3'd5
  } seq_state_t;

  // Sqrt retires two bits per step, so it needs half the iterations (rounded up).
  function automatic int unsigned iter_count(input op_t op, input int unsigned width);
    if (op == OP_SQRT) begin
      return (width + 1) / 2;
    end
    return width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iter_counter.sv
`default_nettype none
// ============================================================================
//  Module      : iter_counter
//  Description : Loadable up-counter with clear, enable and a terminal-count
//                flag that compares against a run-time terminal value.
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  // Counter register: clear dominates load, load dominates increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == term);

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Moore controller for the shared iterative multiply / divide /
//                sqrt datapath. Captures opcode and operand flags on start,
//                screens illegal operations, then issues one init cycle and
//                N step cycles, reporting busy/done/error/result sign.
//  Options     : ALU_SEQ_PENDING_START_EN - one-deep buffer for a start that
//                arrives while busy; replayed straight after FINISH/ERROR.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WORD_LENGHT = 8,
  parameter int CNT_W       = $clog2(WORD_LENGHT) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_in,
  input  logic [1:0]             opCode,
  input  logic                   sign_1,
  input  logic                   sign_2,
  input  logic [WORD_LENGHT-1:0] operand_2,
  output logic [1:0]             dp_sel,
  output logic                   dp_init,
  output logic                   dp_step,
  output logic [CNT_W-1:0]       step_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   result_sign,
  output logic                   result_valid
);

  seq_state_t       state;
  op_t              cap_op;
  logic             cap_s1;
  logic             cap_s2;
  logic             cap_zero;

  logic [CNT_W-1:0] last_idx;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;
  logic             illegal;

  // Source of the operation being accepted this cycle (live inputs or buffer).
  logic             acc_go;
  op_t              acc_op;
  logic             acc_s1;
  logic             acc_s2;
  logic             acc_zero;

`ifdef ALU_SEQ_PENDING_START_EN
  logic             pend_valid;
  op_t              pend_op;
  logic             pend_s1;
  logic             pend_s2;
  logic             pend_zero;
`endif

  assign illegal  = ((cap_op == OP_SQRT) && cap_s1) ||
                    ((cap_op == OP_DIV) && cap_zero) ||
                    (cap_op == OP_RSV);
  assign last_idx = CNT_W'(iter_count(cap_op, WORD_LENGHT) - 1);

  // The counter only runs in ITER; it holds N-1 through the exit cycle and
  // is cleared everywhere else so step_idx reads 0 when not iterating.
  assign cnt_clr  = (state != ST_ITER);
  assign cnt_en   = (state == ST_ITER) && !cnt_tc;

  iter_counter #(
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (cnt_en),
    .term     (last_idx),
    .count    (step_idx),
    .tc       (cnt_tc)
  );

  // Select which operation (if any) is accepted this cycle.
  always_comb begin
    acc_op   = op_t'(opCode);
    acc_s1   = sign_1;
    acc_s2   = sign_2;
    acc_zero = (operand_2 == '0);
`ifdef ALU_SEQ_PENDING_START_EN
    if (pend_valid && ((state == ST_FINISH) || (state == ST_ERROR))) begin
      acc_op   = pend_op;
      acc_s1   = pend_s1;
      acc_s2   = pend_s2;
      acc_zero = pend_zero;
    end
    acc_go = ((state == ST_IDLE) && start_in) ||
             (((state == ST_FINISH) || (state == ST_ERROR)) && (pend_valid || start_in));
`else
    acc_go = (state == ST_IDLE) && start_in;
`endif
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cap_op       <= OP_DIV;
      cap_s1       <= 1'b0;
      cap_s2       <= 1'b0;
      cap_zero     <= 1'b0;
      dp_sel       <= 2'b00;
      dp_init      <= 1'b0;
      dp_step      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      result_sign  <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      dp_init <= 1'b0;
      done    <= 1'b0;
      if (acc_go) begin
        state        <= ST_CHECK;
        cap_op       <= acc_op;
        cap_s1       <= acc_s1;
        cap_s2       <= acc_s2;
        cap_zero     <= acc_zero;
        dp_sel       <= acc_op;
        busy         <= 1'b1;
        error        <= 1'b0;
        result_sign  <= 1'b0;
        result_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
          end
          ST_CHECK: begin
            if (illegal) begin
              state <= ST_ERROR;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              state   <= ST_INIT;
              dp_init <= 1'b1;
            end
          end
          ST_INIT: begin
            state   <= ST_ITER;
            dp_step <= 1'b1;
          end
          ST_ITER: begin
            if (cnt_tc) begin
              state        <= ST_FINISH;
              dp_step      <= 1'b0;
              done         <= 1'b1;
              result_valid <= 1'b1;
              result_sign  <= (cap_op == OP_SQRT) ? 1'b0 : (cap_s1 ^ cap_s2);
            end
          end
          ST_FINISH, ST_ERROR: begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            dp_sel <= 2'b00;
          end
          default: begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            dp_sel  <= 2'b00;
            dp_step <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ALU_SEQ_PENDING_START_EN
  // One-deep pending buffer: filled by a start during CHECK/INIT/ITER, drained
  // when the FINISH/ERROR cycle replays it; extra starts while full are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_op    <= OP_DIV;
      pend_s1    <= 1'b0;
      pend_s2    <= 1'b0;
      pend_zero  <= 1'b0;
    end else if (acc_go && pend_valid && (state != ST_IDLE)) begin
      pend_valid <= 1'b0;
    end else if (start_in && !pend_valid &&
                 ((state == ST_CHECK) || (state == ST_INIT) || (state == ST_ITER))) begin
      pend_valid <= 1'b1;
      pend_op    <= op_t'(opCode);
      pend_s1    <= sign_1;
      pend_s2    <= sign_2;
      pend_zero  <= (operand_2 == '0);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer (WORD_LENGHT=8).
//                Table of directed operations plus hand-written sequences
//                for mid-operation reset and start-while-busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_in = 1'b0;
  logic [1:0] opCode = 2'b00;
  logic       sign_1 = 1'b0;
  logic       sign_2 = 1'b0;
  logic [7:0] operand_2 = 8'd0;
  logic [1:0] dp_sel;
  logic       dp_init;
  logic       dp_step;
  logic [3:0] step_idx;
  logic       busy;
  logic       done;
  logic       error;
  logic       result_sign;
  logic       result_valid;

  int errors = 0;
  int checks = 0;

  alu_sequencer #(
    .WORD_LENGHT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_in     (start_in),
    .opCode       (opCode),
    .sign_1       (sign_1),
    .sign_2       (sign_2),
    .operand_2    (operand_2),
    .dp_sel       (dp_sel),
    .dp_init      (dp_init),
    .dp_step      (dp_step),
    .step_idx     (step_idx),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .result_sign  (result_sign),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic       s1;
    logic       s2;
    logic [7:0] o2;
    int         exp_err;
    int         exp_steps;
    int         exp_done;
    int         exp_sign;
  } vec_t;

  typedef struct {
    int init_cyc;
    int init_cnt;
    int first_step;
    int step_cnt;
    int idx_bad;
    int done_cyc;
    int done_cnt;
    int err_d;
    int rv_d;
    int sign_d;
    int busy_after;
    int err_c1;
    int sel_c1;
    int rv_end;
  } meas_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start in cycle 0 and observe cycles 1..16.
  task automatic run_op(input logic [1:0] op, input logic s1, input logic s2,
                        input logic [7:0] o2, output meas_t m);
    m = '{init_cyc: -1, init_cnt: 0, first_step: -1, step_cnt: 0, idx_bad: 0,
          done_cyc: -1, done_cnt: 0, err_d: -1, rv_d: -1, sign_d: -1,
          busy_after: -1, err_c1: -1, sel_c1: -1, rv_end: -1};
    @(posedge clk); #1;
    opCode = op; sign_1 = s1; sign_2 = s2; operand_2 = o2; start_in = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      start_in = 1'b0;
      if (c == 1) begin
        m.err_c1 = int'(error);
        m.sel_c1 = int'(dp_sel);
      end
      if (dp_init) begin
        m.init_cnt++;
        if (m.init_cyc < 0) m.init_cyc = c;
      end
      if (dp_step) begin
        if (int'(step_idx) != m.step_cnt) m.idx_bad++;
        m.step_cnt++;
        if (m.first_step < 0) m.first_step = c;
      end
      if (done) begin
        m.done_cnt++;
        if (m.done_cyc < 0) begin
          m.done_cyc = c;
          m.err_d    = int'(error);
          m.rv_d     = int'(result_valid);
          m.sign_d   = int'(result_sign);
        end
      end
      if (m.done_cyc >= 0 && c == m.done_cyc + 1) m.busy_after = int'(busy);
      if (c == 16) m.rv_end = int'(result_valid);
    end
  endtask

  vec_t  vecs[8];
  meas_t m;

  initial begin
    vecs[0] = '{op: 2'b10, s1: 1'b1, s2: 1'b0, o2: 8'd3,   exp_err: 0, exp_steps: 8, exp_done: 11, exp_sign: 1};
    vecs[1] = '{op: 2'b01, s1: 1'b0, s2: 1'b1, o2: 8'd0,   exp_err: 0, exp_steps: 4, exp_done: 7,  exp_sign: 0};
    vecs[2] = '{op: 2'b00, s1: 1'b0, s2: 1'b0, o2: 8'd0,   exp_err: 1, exp_steps: 0, exp_done: 2,  exp_sign: 0};
    vecs[3] = '{op: 2'b01, s1: 1'b1, s2: 1'b0, o2: 8'd9,   exp_err: 1, exp_steps: 0, exp_done: 2,  exp_sign: 0};
    vecs[4] = '{op: 2'b11, s1: 1'b0, s2: 1'b0, o2: 8'd9,   exp_err: 1, exp_steps: 0, exp_done: 2,  exp_sign: 0};
    vecs[5] = '{op: 2'b00, s1: 1'b1, s2: 1'b1, o2: 8'd5,   exp_err: 0, exp_steps: 8, exp_done: 11, exp_sign: 0};
    vecs[6] = '{op: 2'b10, s1: 1'b0, s2: 1'b1, o2: 8'd0,   exp_err: 0, exp_steps: 8, exp_done: 11, exp_sign: 1};
    vecs[7] = '{op: 2'b00, s1: 1'b1, s2: 1'b0, o2: 8'd255, exp_err: 0, exp_steps: 8, exp_done: 11, exp_sign: 1};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_dp_sel", int'(dp_sel), 0);
    chk("rst_dp_init", int'(dp_init), 0);
    chk("rst_dp_step", int'(dp_step), 0);
    chk("rst_step_idx", int'(step_idx), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_result_sign", int'(result_sign), 0);
    rst = 1'b0;

    // Directed operation table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].o2, m);
      chk($sformatf("v%0d_done_cycle", i), m.done_cyc, vecs[i].exp_done);
      chk($sformatf("v%0d_done_count", i), m.done_cnt, 1);
      chk($sformatf("v%0d_init_cycle", i), m.init_cyc, vecs[i].exp_err != 0 ? -1 : 2);
      chk($sformatf("v%0d_init_count", i), m.init_cnt, vecs[i].exp_err != 0 ? 0 : 1);
      chk($sformatf("v%0d_step_count", i), m.step_cnt, vecs[i].exp_steps);
      chk($sformatf("v%0d_first_step", i), m.first_step, vecs[i].exp_err != 0 ? -1 : 3);
      chk($sformatf("v%0d_step_idx_seq", i), m.idx_bad, 0);
      chk($sformatf("v%0d_error_at_done", i), m.err_d, vecs[i].exp_err);
      chk($sformatf("v%0d_valid_at_done", i), m.rv_d, vecs[i].exp_err != 0 ? 0 : 1);
      if (vecs[i].exp_err == 0) chk($sformatf("v%0d_sign", i), m.sign_d, vecs[i].exp_sign);
      chk($sformatf("v%0d_busy_after_done", i), m.busy_after, 0);
      chk($sformatf("v%0d_error_cleared_c1", i), m.err_c1, 0);
      chk($sformatf("v%0d_dp_sel_c1", i), m.sel_c1, int'(vecs[i].op));
      chk($sformatf("v%0d_valid_held", i), m.rv_end, vecs[i].exp_err != 0 ? 0 : 1);
    end

    // Reset during ITER at step_idx=3, then a normal operation
    begin
      int found;
      found = 0;
      @(posedge clk); #1;
      opCode = 2'b10; sign_1 = 1'b1; sign_2 = 1'b0; operand_2 = 8'd3; start_in = 1'b1;
      for (int c = 1; c <= 14; c++) begin
        @(posedge clk); #1;
        start_in = 1'b0;
        if (dp_step && step_idx == 4'd3) begin
          found = c;
          break;
        end
      end
      chk("midrst_step3_cycle", found, 6);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_dp_step", int'(dp_step), 0);
      chk("midrst_step_idx", int'(step_idx), 0);
      chk("midrst_dp_sel", int'(dp_sel), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_result_valid", int'(result_valid), 0);
      run_op(2'b10, 1'b1, 1'b0, 8'd3, m);
      chk("after_rst_done_cycle", m.done_cyc, 11);
      chk("after_rst_steps", m.step_cnt, 8);
      chk("after_rst_sign", m.sign_d, 1);
      chk("after_rst_valid", m.rv_d, 1);
    end

    // Start pulse in cycle 5 of a multiply
    begin
      int d1, d2, dcnt, busy12, steps;
      d1 = -1; d2 = -1; dcnt = 0; busy12 = -1; steps = 0;
      @(posedge clk); #1;
      opCode = 2'b10; sign_1 = 1'b0; sign_2 = 1'b0; operand_2 = 8'd7; start_in = 1'b1;
      for (int c = 1; c <= 30; c++) begin
        @(posedge clk); #1;
        start_in = (c == 5);
        if (done) begin
          dcnt++;
          if (d1 < 0) d1 = c;
          else if (d2 < 0) d2 = c;
        end
        if (dp_step) steps++;
        if (c == 12) busy12 = int'(busy);
      end
      start_in = 1'b0;
      chk("busy_start_first_done", d1, 11);
`ifdef ALU_SEQ_PENDING_START_EN
      chk("busy_start_done_count", dcnt, 2);
      chk("busy_start_second_done", d2, 22);
      chk("busy_start_busy_c12", busy12, 1);
      chk("busy_start_steps", steps, 16);
`else
      chk("busy_start_done_count", dcnt, 1);
      chk("busy_start_second_done", d2, -1);
      chk("busy_start_busy_c12", busy12, 0);
      chk("busy_start_steps", steps, 8);
`endif
      chk("busy_start_idle_end", int'(busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
